// File: rtl/memory_responder.sv
// Byte-organised data memory serving 8/16-bit little-endian requests from the address path.
// One byte is accessed per cycle and completion is flagged by a single-cycle ack.
module memory_responder #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [15:0] data,
    input  logic        req,
    input  logic        wr,
    input  logic        wide,
    output logic        ack,
    output logic        busy,
    output logic [15:0] mem_out
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept_c;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr1_c;
    logic [15:0]     data_q;
    logic            wr_q;
    logic            wide_q;
    logic [7:0]      rd_lo_q;
    logic [7:0]      mem [DEPTH];
    logic            unused_addr_hi;

    // Only the low AW address bits select a location; the rest alias.
    assign unused_addr_hi = ^address;
    assign addr1_c        = addr_q + AW'(1);

    // Next-state decode.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = BYTE0;
                    accept_c = 1'b1;
                end
            end
            BYTE0:   state_d = wide_q ? BYTE1 : DONE;
            BYTE1:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, read capture and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            wide_q  <= 1'b0;
            rd_lo_q <= '0;
            mem_out <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack     <= (state_d == DONE);
            busy    <= (state_d != IDLE);
            if (accept_c) begin
                addr_q <= address[AW-1:0];
                data_q <= data;
                wr_q   <= wr;
                wide_q <= wide;
            end
            if (state_q == BYTE0 && !wr_q) begin
                if (wide_q) begin
                    rd_lo_q <= mem[addr_q];
                end else begin
                    mem_out <= {8'h00, mem[addr_q]};
                end
            end
            if (state_q == BYTE1 && !wr_q) begin
                mem_out <= {mem[addr1_c], rd_lo_q};
            end
        end
    end

    // Storage is never reset; writes are gated by the state so an aborted request stops cleanly.
    always_ff @(posedge clk) begin
        if (state_q == BYTE0 && wr_q) begin
            mem[addr_q] <= data_q[7:0];
        end
        if (state_q == BYTE1 && wr_q) begin
            mem[addr1_c] <= data_q[15:8];
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: requests push expected results, a monitor checks each ack.
module tb_memory_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] data;
    logic        req;
    logic        wr;
    logic        wide;
    logic        ack;
    logic        busy;
    logic [15:0] mem_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Each entry: {expected mem_out, wide flag}
    logic [16:0] sb_q[$];
    int          ack_cyc_q[$];

    memory_responder #(.DEPTH(1024)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data),
        .req     (req),
        .wr      (wr),
        .wide    (wide),
        .ack     (ack),
        .busy    (busy),
        .mem_out (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks data and latency.
    logic prev_ack  = 1'b0;
    logic prev_busy = 1'b0;
    int   rise_cyc  = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            prev_ack  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) rise_cyc = cyc;
            if (ack) begin
                ack_cyc_q.push_back(cyc);
                if (prev_ack) check("ack_back_to_back", 16'(1), 16'(0));
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 16'(1), 16'(0));
                end else begin
                    logic [16:0] e;
                    e = sb_q.pop_front();
                    check("mem_out", mem_out, e[16:1]);
                    check("ack_latency", 16'(cyc - rise_cyc + 1), e[0] ? 16'(3) : 16'(2));
                end
            end
            prev_ack  = ack;
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 12; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", 16'(1), 16'(0));
    endtask

    task automatic txn(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic wd, input logic [15:0] exp);
        sb_q.push_back({exp, wd});
        @(negedge clk);
        address = a; data = d; wr = w; wide = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        address = 16'($urandom);
        data    = 16'($urandom);
        wr      = ~w;
        wide    = ~wd;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; wide = 1'b0; address = '0; data = '0;
        #1;
        check("reset_ack", 16'(ack), 16'(0));
        check("reset_busy", 16'(busy), 16'(0));
        check("reset_mem_out", mem_out, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ack", 16'(ack), 16'(0));
        check("idle_busy", 16'(busy), 16'(0));
        check("idle_mem_out", mem_out, 16'h0000);

        // Narrow write then read
        txn(16'h0010, 16'h00A5, 1'b1, 1'b0, 16'h0000);
        txn(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h00A5);
        // Wide write then narrow/wide reads
        txn(16'h0020, 16'hBEEF, 1'b1, 1'b1, 16'h00A5);
        txn(16'h0020, 16'h0000, 1'b0, 1'b0, 16'h00EF);
        txn(16'h0021, 16'h0000, 1'b0, 1'b0, 16'h00BE);
        txn(16'h0020, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        // Wrap-around at DEPTH-1
        txn(16'h03FF, 16'h1234, 1'b1, 1'b1, 16'hBEEF);
        txn(16'h03FF, 16'h0000, 1'b0, 1'b0, 16'h0034);
        txn(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0012);
        txn(16'h07FF, 16'h0000, 1'b0, 1'b1, 16'h1234);

        // Req held high through three wide reads; address scrambled while busy
        ack_cyc_q.delete();
        repeat (3) sb_q.push_back({16'hBEEF, 1'b1});
        @(negedge clk);
        address = 16'h0020; wr = 1'b0; wide = 1'b1; req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i >= 9) req = 1'b0;
            address = busy ? 16'($urandom) : 16'h0020;
        end
        wait_idle();
        check("held_ack_count", 16'(ack_cyc_q.size()), 16'(3));
        if (ack_cyc_q.size() == 3) begin
            check("held_ack_gap0", 16'(ack_cyc_q[1] - ack_cyc_q[0]), 16'(4));
            check("held_ack_gap1", 16'(ack_cyc_q[2] - ack_cyc_q[1]), 16'(4));
        end

        // Reset during BYTE1 of a wide write
        txn(16'h0041, 16'h0077, 1'b1, 1'b0, 16'hBEEF);
        @(negedge clk);
        address = 16'h0040; data = 16'hCAFE; wr = 1'b1; wide = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 16'(busy), 16'(0));
        check("abort_ack", 16'(ack), 16'(0));
        check("abort_mem_out", mem_out, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(16'h0040, 16'h0000, 1'b0, 1'b0, 16'h00FE);
        txn(16'h0041, 16'h0000, 1'b0, 1'b0, 16'h0077);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 16'(sb_q.size()), 16'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-organised data memory that serves as the target end of the address path: it accepts a request carrying a 16-bit address from the address register file outputs (PC/SP/AR via OutC/OutD), then performs single-byte or two-byte little-endian reads and writes. Each request is executed by a small FSM, one byte per cycle, and completion is signalled by a one-cycle acknowledge. It sits between the address register file, the ALU/data bus and the instruction/data registers.

## Interface

- DEPTH, 1024, number of byte locations; power of two, 2 ≤ DEPTH ≤ 65536.
- Clock  input  1  single system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Address  input  16  byte address of the request; sampled only at acceptance.
- Data  input  16  write data; sampled only at acceptance.
- Req  input  1  request strobe; sampled only in IDLE.
- WR  input  1  1 = write, 0 = read; sampled at acceptance.
- Wide  input  1  1 = 16-bit access at A and A+1, 0 = 8-bit access at A; sampled at acceptance.
- Ack  output  1  one-cycle completion pulse.
- Busy  output  1  high whenever state ≠ IDLE.
- MemOut  output  16  read data; holds its value until the next read completes.

## Operation

- Effective address: A = Address mod DEPTH. The second byte address is (A+1) mod DEPTH, so DEPTH−1 wraps to 0.
- FSM states: IDLE, BYTE0, BYTE1, DONE.
- IDLE:
  - If Req=1, latch Address, Data, WR and Wide, then go to BYTE0.
  - Otherwise remain in IDLE.
- BYTE0: access location A.
  - Write: mem[A] ← Data[7:0].
  - Read: capture mem[A] into the low byte.
  - Next state is BYTE1 if Wide=1, else DONE.
- BYTE1: access location (A+1) mod DEPTH, then go to DONE.
  - Write: mem[A+1] ← Data[15:8].
  - Read: capture mem[A+1] into the high byte.
- DONE: Ack=1 for exactly this cycle, then go to IDLE.
- MemOut update (on the edge entering DONE):
  - Narrow read: MemOut ← {8'h00, mem[A]}.
  - Wide read: MemOut ← {mem[A+1], mem[A]}.
  - Writes never change MemOut.
- Req is ignored in BYTE0, BYTE1 and DONE; it is not queued. A request held high through DONE is accepted again in the following IDLE cycle.
- Busy = (state ≠ IDLE). Ack = (state == DONE).
- Reset (Reset=0, asynchronous):
  - State → IDLE; Ack=0, Busy=0, MemOut=16'h0000.
  - Memory contents are not cleared.
- Reset mid-transaction: the transaction is aborted with no Ack. A byte written on an edge before reset asserted stays committed; no later byte is written.
- A read after a write to the same address returns the new data, because the write commits before the read is accepted.

## Timing

- Edge e0 samples Req=1 in IDLE; Busy rises after e0.
- Narrow access:
  - Access happens on edge e1.
  - Ack and the new MemOut are visible after e1, for one cycle.
  - Back in IDLE after e2.
- Wide access:
  - Byte accesses happen on e1 and e2.
  - Ack and MemOut are visible after e2.
  - Back in IDLE after e3.
- Maximum throughput:
  - Narrow: one transaction per 3 cycles.
  - Wide: one transaction per 4 cycles (includes the IDLE acceptance cycle).
- Memory reads are synchronous: the byte is captured on the BYTE0/BYTE1 edge. No combinational path runs from Address to MemOut.
- Ack is never high in two consecutive cycles.

## Test plan

- Reset with Req=0: Ack=0, Busy=0, MemOut=0x0000. Release reset and idle 5 cycles: outputs unchanged.
- Narrow write then read:
  - Write Address=0x0010, Data=0x00A5, Wide=0: Ack high exactly 2 cycles after acceptance, MemOut stays 0x0000.
  - Read 0x0010 narrow: MemOut=0x00A5 with Ack.
- Wide write then reads:
  - Write Address=0x0020, Data=0xBEEF, Wide=1: Ack 3 cycles after acceptance.
  - Narrow read 0x0020 → 0x00EF; narrow read 0x0021 → 0x00BE; wide read 0x0020 → 0xBEEF.
- Wrap-around with DEPTH=1024:
  - Wide write at Address=0x03FF, Data=0x1234: mem[0x3FF]=0x34, mem[0x000]=0x12.
  - Wide read at 0x07FF (aliases to 0x3FF) → 0x1234.
- Req held high continuously during a wide read: exactly one Ack per 4 cycles, and Address changes made while Busy=1 do not alter the accessed location.
- Reset asserted in BYTE1 of a wide write of 0xCAFE at 0x0040:
  - Immediately Busy=0, no Ack, MemOut=0x0000.
  - After release, narrow read 0x0040 → 0x00FE; 0x0041 holds its prior value.
